// File: rtl/mem_access_stage.sv
// Memory-access stage: issues one outstanding load/store to the data cache, aligns store
// byte lanes, extends load data and registers the write-back results.
module mem_access_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [XLEN-1:0] WB_DATA_IN,
    input  logic [XLEN-1:0] DATA_ADDRESS,
    input  logic [XLEN-1:0] STORE_DATA,
    input  logic [1:0]      DATA_CACHE_CONTROL,
    input  logic [2:0]      FUN3,
    input  logic [4:0]      RD_IN,
    input  logic            WB_EN_IN,
    output logic            CACHE_REQ,
    output logic            CACHE_WE,
    output logic [XLEN-1:0] CACHE_ADDR,
    output logic [3:0]      CACHE_WSTRB,
    output logic [XLEN-1:0] CACHE_WDATA,
    input  logic            CACHE_ACK,
    input  logic [XLEN-1:0] CACHE_RDATA,
    output logic            MEM_STALL,
    output logic            MISALIGNED,
    output logic [XLEN-1:0] WB_DATA,
    output logic [4:0]      RD_OUT,
    output logic            WB_EN_OUT
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [4:0]        rd_q, rd_d;
    logic              wb_en_q, wb_en_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              misaligned_q, misaligned_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic              wb_en_out_q, wb_en_out_d;

    logic              is_mem, is_store, aligned, accept, done;
    logic [1:0]        size_in;
    logic [3:0]        wstrb_in;
    logic [XLEN-1:0]   wdata_in, load_val;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;

    assign is_store = (DATA_CACHE_CONTROL == 2'b01);
    assign is_mem   = (DATA_CACHE_CONTROL == 2'b01) || (DATA_CACHE_CONTROL == 2'b10);
    // Size code: 00 byte, 01 half, 10 word.
    assign size_in  = (FUN3[1:0] == 2'b11) ? 2'b10 : FUN3[1:0];
    assign done     = (state_q == StWait) && CACHE_ACK;
    // The op held upstream is consumed on the acknowledging edge, so issue has no gap.
    assign accept   = (state_q == StIdle) || CACHE_ACK;

    always_comb begin
        aligned  = 1'b1;
        wstrb_in = 4'b1111;
        wdata_in = STORE_DATA;
        unique case (size_in)
            2'b00: begin
                wstrb_in = 4'b0001 << DATA_ADDRESS[1:0];
                wdata_in = {4{STORE_DATA[7:0]}};
            end
            2'b01: begin
                aligned  = ~DATA_ADDRESS[0];
                wstrb_in = 4'b0011 << DATA_ADDRESS[1:0];
                wdata_in = {2{STORE_DATA[15:0]}};
            end
            default: aligned = (DATA_ADDRESS[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        byte_lane = CACHE_RDATA[{addr_q[1:0], 3'b000} +: 8];
        half_lane = CACHE_RDATA[{addr_q[1], 4'b0000} +: 16];
        unique case (size_q)
            2'b00:   load_val = {{24{sign_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_val = {{16{sign_q & half_lane[15]}}, half_lane};
            default: load_val = CACHE_RDATA;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        size_d       = size_q;
        sign_d       = sign_q;
        rd_d         = rd_q;
        wb_en_d      = wb_en_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        misaligned_d = 1'b0;
        wb_data_d    = wb_data_q;
        rd_out_d     = rd_out_q;
        wb_en_out_d  = wb_en_out_q;

        if (accept) begin
            if (!is_mem) begin
                state_d     = StIdle;
                wb_data_d   = WB_DATA_IN;
                rd_out_d    = RD_IN;
                wb_en_out_d = WB_EN_IN;
            end else if (!aligned) begin
                state_d      = StIdle;
                misaligned_d = 1'b1;
                wb_en_out_d  = 1'b0;
            end else begin
                state_d     = StWait;
                we_d        = is_store;
                addr_d      = DATA_ADDRESS;
                size_d      = size_in;
                sign_d      = ~FUN3[2];
                rd_d        = RD_IN;
                wb_en_d     = WB_EN_IN;
                wstrb_d     = is_store ? wstrb_in : 4'b0000;
                wdata_d     = is_store ? wdata_in : '0;
                wb_en_out_d = 1'b0;
            end
        end

        // Completion of the in-flight access owns the write-back registers.
        if (done) begin
            if (we_q) begin
                wb_en_out_d = 1'b0;
            end else begin
                wb_data_d   = load_val;
                rd_out_d    = rd_q;
                wb_en_out_d = wb_en_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            addr_q       <= '0;
            size_q       <= 2'b00;
            sign_q       <= 1'b0;
            rd_q         <= 5'd0;
            wb_en_q      <= 1'b0;
            wstrb_q      <= 4'b0000;
            wdata_q      <= '0;
            misaligned_q <= 1'b0;
            wb_data_q    <= '0;
            rd_out_q     <= 5'd0;
            wb_en_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            rd_q         <= rd_d;
            wb_en_q      <= wb_en_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
            misaligned_q <= misaligned_d;
            wb_data_q    <= wb_data_d;
            rd_out_q     <= rd_out_d;
            wb_en_out_q  <= wb_en_out_d;
        end
    end

    assign CACHE_REQ   = (state_q == StWait);
    assign CACHE_WE    = we_q;
    assign CACHE_ADDR  = {addr_q[XLEN-1:2], 2'b00};
    assign CACHE_WSTRB = wstrb_q;
    assign CACHE_WDATA = wdata_q;
    assign MEM_STALL   = (state_q == StWait) && !CACHE_ACK;
    assign MISALIGNED  = misaligned_q;
    assign WB_DATA     = wb_data_q;
    assign RD_OUT      = rd_out_q;
    assign WB_EN_OUT   = wb_en_out_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected write-backs are queued at issue and
// compared when the stage retires them.
module tb_mem_access_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] WB_DATA_IN, DATA_ADDRESS, STORE_DATA, CACHE_RDATA;
    logic [1:0]  DATA_CACHE_CONTROL;
    logic [2:0]  FUN3;
    logic [4:0]  RD_IN;
    logic        WB_EN_IN, CACHE_ACK;
    logic        CACHE_REQ, CACHE_WE, MEM_STALL, MISALIGNED, WB_EN_OUT;
    logic [31:0] CACHE_ADDR, CACHE_WDATA, WB_DATA;
    logic [3:0]  CACHE_WSTRB;
    logic [4:0]  RD_OUT;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        en;
        logic        full; // 0: only the enable is meaningful (stores)
    } wb_t;

    wb_t sb_q[$];
    wb_t exp;
    int  errors = 0;
    int  checks = 0;

    mem_access_stage #(.XLEN(32)) dut (
        .CLK(CLK), .RST(RST), .WB_DATA_IN(WB_DATA_IN), .DATA_ADDRESS(DATA_ADDRESS),
        .STORE_DATA(STORE_DATA), .DATA_CACHE_CONTROL(DATA_CACHE_CONTROL), .FUN3(FUN3),
        .RD_IN(RD_IN), .WB_EN_IN(WB_EN_IN), .CACHE_REQ(CACHE_REQ), .CACHE_WE(CACHE_WE),
        .CACHE_ADDR(CACHE_ADDR), .CACHE_WSTRB(CACHE_WSTRB), .CACHE_WDATA(CACHE_WDATA),
        .CACHE_ACK(CACHE_ACK), .CACHE_RDATA(CACHE_RDATA), .MEM_STALL(MEM_STALL),
        .MISALIGNED(MISALIGNED), .WB_DATA(WB_DATA), .RD_OUT(RD_OUT), .WB_EN_OUT(WB_EN_OUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_idle();
        DATA_CACHE_CONTROL = 2'b00;
        WB_EN_IN = 1'b0; WB_DATA_IN = '0; RD_IN = '0;
        DATA_ADDRESS = '0; STORE_DATA = '0; FUN3 = '0; CACHE_ACK = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; DATA_CACHE_CONTROL = 2'b10; FUN3 = 3'b010; DATA_ADDRESS = 32'h40;
        WB_EN_IN = 1'b1; WB_DATA_IN = 32'hFFFF_FFFF; RD_IN = 5'd31; STORE_DATA = 32'hFFFF_FFFF;
        CACHE_ACK = 1'b0; CACHE_RDATA = '0;
        tick(); tick();
        checks++;
        if ({CACHE_REQ, CACHE_WE, MEM_STALL, MISALIGNED, WB_EN_OUT} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req/we/stall/mis/wben=%b required 00000",
                     {CACHE_REQ, CACHE_WE, MEM_STALL, MISALIGNED, WB_EN_OUT});
        end
        checks++;
        if ({CACHE_ADDR, CACHE_WSTRB, CACHE_WDATA} !== 68'h0) begin
            errors++;
            $display("FAIL reset_cache: addr=%h wstrb=%b wdata=%h required zeros",
                     CACHE_ADDR, CACHE_WSTRB, CACHE_WDATA);
        end
        checks++;
        if (WB_DATA !== 32'h0 || RD_OUT !== 5'd0) begin
            errors++;
            $display("FAIL reset_wb: wb_data=%h rd=%0d required 0", WB_DATA, RD_OUT);
        end
        RST = 1'b0;
        set_idle();
        tick();
    endtask

    task automatic test_alu();
        logic [31:0] d;
        logic [4:0]  r;
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? 32'h1234_5678 : $urandom();
            r = (i == 0) ? 5'd5 : 5'($urandom_range(1, 31));
            DATA_CACHE_CONTROL = (i == 2) ? 2'b11 : 2'b00;
            WB_DATA_IN = d; RD_IN = r; WB_EN_IN = (i != 3);
            CACHE_ACK = (i == 1); // stray ack while idle
            DATA_ADDRESS = 32'h0000_0101; FUN3 = 3'b010;
            sb_q.push_back(wb_t'{d, r, (i != 3), 1'b1});
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (WB_DATA !== exp.data || RD_OUT !== exp.rd || WB_EN_OUT !== exp.en) begin
                errors++;
                $display("FAIL alu_wb[%0d]: data=%h rd=%0d en=%b required %h %0d %b",
                         i, WB_DATA, RD_OUT, WB_EN_OUT, exp.data, exp.rd, exp.en);
            end
            checks++;
            if (MEM_STALL !== 1'b0 || CACHE_REQ !== 1'b0 || MISALIGNED !== 1'b0) begin
                errors++;
                $display("FAIL alu_ctrl[%0d]: stall=%b req=%b mis=%b required 0 0 0",
                         i, MEM_STALL, CACHE_REQ, MISALIGNED);
            end
        end
        set_idle();
    endtask

    logic [31:0] ld_addr[7], ld_rdata[7], ld_exp[7];
    logic [2:0]  ld_f3[7];
    int          ld_wait[7];

    task automatic test_load();
        int stalls;
        ld_addr = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h104, 32'h101, 32'h100};
        ld_f3   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001};
        ld_rdata = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000,
                     32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_F00D};
        ld_exp  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                    32'hDEAD_BEEF, 32'h0000_0056, 32'hFFFF_F00D};
        ld_wait = '{3, 3, 0, 1, 0, 2, 1};
        for (int i = 0; i < 7; i++) begin
            DATA_CACHE_CONTROL = 2'b10; DATA_ADDRESS = ld_addr[i]; FUN3 = ld_f3[i];
            RD_IN = 5'(10 + i); WB_EN_IN = 1'b1; WB_DATA_IN = 32'h5555_5555;
            sb_q.push_back(wb_t'{ld_exp[i], 5'(10 + i), 1'b1, 1'b1});
            tick();
            set_idle();
            WB_DATA_IN = 32'hA5A5_0000;
            checks++;
            if (CACHE_REQ !== 1'b1 || CACHE_WE !== 1'b0 ||
                CACHE_ADDR !== {ld_addr[i][31:2], 2'b00} || WB_EN_OUT !== 1'b0) begin
                errors++;
                $display("FAIL load_req[%0d]: req=%b we=%b addr=%h wben=%b required 1 0 %h 0",
                         i, CACHE_REQ, CACHE_WE, CACHE_ADDR, WB_EN_OUT,
                         {ld_addr[i][31:2], 2'b00});
            end
            stalls = 0;
            for (int w = 0; w < ld_wait[i]; w++) begin
                #1;
                if (MEM_STALL === 1'b1) stalls++;
                tick();
            end
            CACHE_ACK = 1'b1; CACHE_RDATA = ld_rdata[i];
            #1;
            checks++;
            if (MEM_STALL !== 1'b0 || CACHE_REQ !== 1'b1 || stalls != ld_wait[i]) begin
                errors++;
                $display("FAIL load_stall[%0d]: stall=%b req=%b stall_cycles=%0d required 0 1 %0d",
                         i, MEM_STALL, CACHE_REQ, stalls, ld_wait[i]);
            end
            tick();
            CACHE_ACK = 1'b0; CACHE_RDATA = 32'h0;
            exp = sb_q.pop_front();
            checks++;
            if (WB_DATA !== exp.data || RD_OUT !== exp.rd || WB_EN_OUT !== exp.en ||
                CACHE_REQ !== 1'b0) begin
                errors++;
                $display("FAIL load_wb[%0d]: data=%h rd=%0d en=%b req=%b required %h %0d %b 0",
                         i, WB_DATA, RD_OUT, WB_EN_OUT, CACHE_REQ, exp.data, exp.rd, exp.en);
            end
        end
    endtask

    logic [31:0] st_addr[4], st_data[4], st_wdata[4];
    logic [2:0]  st_f3[4];
    logic [3:0]  st_strb[4];
    int          st_wait[4];

    task automatic test_store();
        st_addr  = '{32'h202, 32'h201, 32'h300, 32'h203};
        st_f3    = '{3'b001, 3'b000, 3'b010, 3'b000};
        st_data  = '{32'hAAAA_BEEF, 32'h1234_56A5, 32'hCAFE_F00D, 32'h0000_007E};
        st_strb  = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
        st_wdata = '{32'hBEEF_BEEF, 32'hA5A5_A5A5, 32'hCAFE_F00D, 32'h7E7E_7E7E};
        st_wait  = '{2, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            DATA_CACHE_CONTROL = 2'b01; DATA_ADDRESS = st_addr[i]; FUN3 = st_f3[i];
            STORE_DATA = st_data[i]; RD_IN = 5'd4; WB_EN_IN = 1'b1;
            sb_q.push_back(wb_t'{32'h0, 5'd0, 1'b0, 1'b0});
            tick();
            set_idle();
            checks++;
            if (CACHE_REQ !== 1'b1 || CACHE_WE !== 1'b1 ||
                CACHE_ADDR !== {st_addr[i][31:2], 2'b00} ||
                CACHE_WSTRB !== st_strb[i] || CACHE_WDATA !== st_wdata[i]) begin
                errors++;
                $display("FAIL store_req[%0d]: req=%b we=%b addr=%h strb=%b wdata=%h required 1 1 %h %b %h",
                         i, CACHE_REQ, CACHE_WE, CACHE_ADDR, CACHE_WSTRB, CACHE_WDATA,
                         {st_addr[i][31:2], 2'b00}, st_strb[i], st_wdata[i]);
            end
            for (int w = 0; w < st_wait[i]; w++) begin
                // Different op at the inputs while waiting must be ignored.
                DATA_CACHE_CONTROL = 2'b01; DATA_ADDRESS = 32'h0F00; STORE_DATA = 32'h0;
                FUN3 = 3'b010;
                tick();
            end
            set_idle();
            CACHE_ACK = 1'b1;
            #1;
            checks++;
            if (CACHE_ADDR !== {st_addr[i][31:2], 2'b00} || CACHE_WSTRB !== st_strb[i] ||
                CACHE_WDATA !== st_wdata[i] || MEM_STALL !== 1'b0) begin
                errors++;
                $display("FAIL store_hold[%0d]: addr=%h strb=%b wdata=%h stall=%b required %h %b %h 0",
                         i, CACHE_ADDR, CACHE_WSTRB, CACHE_WDATA, MEM_STALL,
                         {st_addr[i][31:2], 2'b00}, st_strb[i], st_wdata[i]);
            end
            tick();
            CACHE_ACK = 1'b0;
            exp = sb_q.pop_front();
            checks++;
            if (WB_EN_OUT !== exp.en || CACHE_REQ !== 1'b0) begin
                errors++;
                $display("FAIL store_done[%0d]: wben=%b req=%b required %b 0",
                         i, WB_EN_OUT, CACHE_REQ, exp.en);
            end
        end
    endtask

    logic [31:0] mis_addr[5];
    logic [2:0]  mis_f3[5];
    logic [1:0]  mis_ctl[5];

    task automatic test_misaligned();
        mis_addr = '{32'h101, 32'h203, 32'h102, 32'h301, 32'h205};
        mis_f3   = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b001};
        mis_ctl  = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        for (int i = 0; i < 5; i++) begin
            DATA_CACHE_CONTROL = 2'b00; WB_DATA_IN = 32'(i) + 32'h100; RD_IN = 5'd3;
            WB_EN_IN = 1'b1;
            sb_q.push_back(wb_t'{32'(i) + 32'h100, 5'd3, 1'b1, 1'b1});
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (WB_DATA !== exp.data || WB_EN_OUT !== exp.en) begin
                errors++;
                $display("FAIL mis_pre[%0d]: data=%h en=%b required %h %b",
                         i, WB_DATA, WB_EN_OUT, exp.data, exp.en);
            end
            DATA_CACHE_CONTROL = mis_ctl[i]; DATA_ADDRESS = mis_addr[i]; FUN3 = mis_f3[i];
            STORE_DATA = 32'hFFFF_FFFF; RD_IN = 5'd6;
            tick();
            set_idle();
            checks++;
            if (MISALIGNED !== 1'b1 || CACHE_REQ !== 1'b0 || WB_EN_OUT !== 1'b0 ||
                MEM_STALL !== 1'b0) begin
                errors++;
                $display("FAIL mis_pulse[%0d]: mis=%b req=%b wben=%b stall=%b required 1 0 0 0",
                         i, MISALIGNED, CACHE_REQ, WB_EN_OUT, MEM_STALL);
            end
            tick();
            checks++;
            if (MISALIGNED !== 1'b0 || CACHE_REQ !== 1'b0) begin
                errors++;
                $display("FAIL mis_end[%0d]: mis=%b req=%b required 0 0",
                         i, MISALIGNED, CACHE_REQ);
            end
        end
    endtask

    task automatic test_reset_mid();
        DATA_CACHE_CONTROL = 2'b10; DATA_ADDRESS = 32'h400; FUN3 = 3'b010;
        RD_IN = 5'd7; WB_EN_IN = 1'b1;
        tick();
        set_idle();
        checks++;
        if (CACHE_REQ !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_req: req=%b required 1", CACHE_REQ);
        end
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (CACHE_REQ !== 1'b0 || MEM_STALL !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop: req=%b stall=%b required 0 0", CACHE_REQ, MEM_STALL);
        end
        tick(); tick();
        CACHE_ACK = 1'b1; CACHE_RDATA = 32'hFFFF_FFFF;
        tick();
        CACHE_ACK = 1'b0; CACHE_RDATA = 32'h0;
        checks++;
        if (WB_EN_OUT !== 1'b0 || WB_DATA !== 32'h0 || RD_OUT !== 5'd0 ||
            CACHE_REQ !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_late_ack: wben=%b data=%h rd=%0d req=%b required 0 0 0 0",
                     WB_EN_OUT, WB_DATA, RD_OUT, CACHE_REQ);
        end
    endtask

    task automatic test_back_to_back();
        DATA_CACHE_CONTROL = 2'b10; DATA_ADDRESS = 32'h500; FUN3 = 3'b010;
        RD_IN = 5'd9; WB_EN_IN = 1'b1;
        sb_q.push_back(wb_t'{32'h1122_3344, 5'd9, 1'b1, 1'b1});
        tick();
        // Upstream holds the next op (a store) while the load is outstanding.
        DATA_CACHE_CONTROL = 2'b01; DATA_ADDRESS = 32'h600; FUN3 = 3'b010;
        STORE_DATA = 32'hCAFE_F00D; RD_IN = 5'd0; WB_EN_IN = 1'b0;
        #1;
        checks++;
        if (MEM_STALL !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stall: stall=%b required 1", MEM_STALL);
        end
        tick();
        CACHE_ACK = 1'b1; CACHE_RDATA = 32'h1122_3344;
        tick();
        set_idle();
        exp = sb_q.pop_front();
        checks++;
        if (WB_DATA !== exp.data || RD_OUT !== exp.rd || WB_EN_OUT !== exp.en) begin
            errors++;
            $display("FAIL b2b_load_wb: data=%h rd=%0d en=%b required %h %0d %b",
                     WB_DATA, RD_OUT, WB_EN_OUT, exp.data, exp.rd, exp.en);
        end
        checks++;
        if (CACHE_REQ !== 1'b1 || CACHE_WE !== 1'b1 || CACHE_ADDR !== 32'h600 ||
            CACHE_WSTRB !== 4'b1111 || CACHE_WDATA !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL b2b_store_req: req=%b we=%b addr=%h strb=%b wdata=%h required 1 1 600 1111 cafef00d",
                     CACHE_REQ, CACHE_WE, CACHE_ADDR, CACHE_WSTRB, CACHE_WDATA);
        end
        sb_q.push_back(wb_t'{32'h0, 5'd0, 1'b0, 1'b0});
        CACHE_ACK = 1'b1;
        tick();
        CACHE_ACK = 1'b0;
        exp = sb_q.pop_front();
        checks++;
        if (WB_EN_OUT !== exp.en || CACHE_REQ !== 1'b0) begin
            errors++;
            $display("FAIL b2b_store_done: wben=%b req=%b required %b 0",
                     WB_EN_OUT, CACHE_REQ, exp.en);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
